ysyx_220066_dmem_bridge: RTL and testbench

Data-memory bridge directly downstream of the CPU's M stage. It consumes the M-stage request (`MemRd`/`MemWr`, `addr`, `wr_mask`, `data_Wr`) and returns `data_Rd`/`data_Rd_valid`/`data_Rd_error` to the core. Stores are posted into a small in-order write buffer so they never stall the core unless the buffer is full. Loads and buffered stores are serialized onto a single-outstanding valid/ready memory bus.

---
 rtl/ysyx_220066_dmem_bridge.sv | 168 ++++++++++++++++
 tb/tb_ysyx_220066_dmem_bridge.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220066_dmem_bridge.sv
// ============================================================================
// Module  : ysyx_220066_dmem_bridge
// Brief   : M-stage data-memory bridge with posted in-order write buffer and
//           a single-outstanding valid/ready memory bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_220066_dmem_bridge #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        cpu_block,
  input  logic [63:0] addr,
  input  logic [7:0]  wr_mask,
  input  logic [63:0] data_Wr,
  output logic [63:0] data_Rd,
  output logic        data_Rd_valid,
  output logic        data_Rd_error,
  output logic        data_Wr_error,
  output logic        wr_full,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_wen,
  output logic [63:0] bus_req_addr,
  output logic [7:0]  bus_req_wmask,
  output logic [63:0] bus_req_wdata,
  input  logic        bus_resp_valid,
  input  logic        bus_resp_error,
  input  logic [63:0] bus_resp_rdata
);

  localparam int          PW     = $clog2(WBUF_DEPTH);
  localparam logic [PW:0] c_full = WBUF_DEPTH[PW:0];

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WREQ  = 3'd1,
    S_WRESP = 3'd2,
    S_RREQ  = 3'd3,
    S_RRESP = 3'd4,
    S_RDONE = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [60:0]   r_wb_addr [WBUF_DEPTH];
  logic [7:0]    r_wb_mask [WBUF_DEPTH];
  logic [63:0]   r_wb_data [WBUF_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic [PW:0]   w_count_next;
  logic [60:0]   r_rd_addr;
  logic [60:0]   w_rd_addr;

  logic          w_push;
  logic          w_pop;
  logic          w_hs;
  logic          w_unused_addr;

  assign w_push        = MemWr && !cpu_block && !wr_full;
  assign w_hs          = bus_req_valid && bus_req_ready;
  assign w_pop         = (r_state == S_WREQ) && w_hs;
  assign w_count_next  = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
  // In IDLE the load address comes straight from the core; afterwards it is latched.
  assign w_rd_addr     = (r_state == S_IDLE) ? addr[63:3] : r_rd_addr;
  assign w_unused_addr = ^addr[2:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_state_next = S_WREQ;
        else if (MemRd)    w_state_next = S_RREQ;
      end
      S_WREQ:  if (w_hs)           w_state_next = S_WRESP;
      S_WRESP: if (bus_resp_valid) w_state_next = S_IDLE;
      S_RREQ:  if (w_hs)           w_state_next = S_RRESP;
      S_RRESP: if (bus_resp_valid) w_state_next = S_RDONE;
      S_RDONE:                     w_state_next = S_IDLE;
      default:                     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rd_addr <= '0;
      wr_full   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      wr_full <= (w_count_next == c_full);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (r_state == S_IDLE && w_state_next == S_RREQ) r_rd_addr <= addr[63:3];
    end
  end

  // Buffer payload needs no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_wptr] <= addr[63:3];
      r_wb_mask[r_wptr] <= wr_mask;
      r_wb_data[r_wptr] <= data_Wr;
    end
  end

  // Request fields are loaded from the next state so they are stable for the whole request.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_valid <= 1'b0;
      bus_req_wen   <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wmask <= '0;
      bus_req_wdata <= '0;
    end else begin
      bus_req_valid <= (w_state_next == S_WREQ) || (w_state_next == S_RREQ);
      case (w_state_next)
        S_WREQ: begin
          bus_req_wen   <= 1'b1;
          bus_req_addr  <= {r_wb_addr[r_rptr], 3'b000};
          bus_req_wmask <= r_wb_mask[r_rptr];
          bus_req_wdata <= r_wb_data[r_rptr];
        end
        S_RREQ: begin
          bus_req_wen   <= 1'b0;
          bus_req_addr  <= {w_rd_addr, 3'b000};
          bus_req_wmask <= '0;
          bus_req_wdata <= '0;
        end
        default: begin
          bus_req_wen   <= 1'b0;
          bus_req_addr  <= '0;
          bus_req_wmask <= '0;
          bus_req_wdata <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_Rd       <= '0;
      data_Rd_valid <= 1'b0;
      data_Rd_error <= 1'b0;
      data_Wr_error <= 1'b0;
    end else begin
      data_Rd_valid <= (r_state == S_RRESP) && bus_resp_valid;
      data_Wr_error <= (r_state == S_WRESP) && bus_resp_valid && bus_resp_error;
      if (r_state == S_RRESP && bus_resp_valid) begin
        data_Rd       <= bus_resp_rdata;
        data_Rd_error <= bus_resp_error;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_220066_dmem_bridge.sv
// Directed bench for ysyx_220066_dmem_bridge: a one-cycle-latency bus responder,
// request/response monitor and hand-computed expectations.
`default_nettype none

module tb_ysyx_220066_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst, MemRd, MemWr, cpu_block;
  logic [63:0] addr, data_Wr;
  logic [7:0]  wr_mask;
  logic [63:0] data_Rd;
  logic        data_Rd_valid, data_Rd_error, data_Wr_error, wr_full;
  logic        bus_req_valid, bus_req_ready, bus_req_wen;
  logic [63:0] bus_req_addr, bus_req_wdata;
  logic [7:0]  bus_req_wmask;
  logic        bus_resp_valid, bus_resp_error;
  logic [63:0] bus_resp_rdata;

  ysyx_220066_dmem_bridge #(.WBUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .cpu_block(cpu_block),
    .addr(addr), .wr_mask(wr_mask), .data_Wr(data_Wr),
    .data_Rd(data_Rd), .data_Rd_valid(data_Rd_valid), .data_Rd_error(data_Rd_error),
    .data_Wr_error(data_Wr_error), .wr_full(wr_full),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_wen(bus_req_wen),
    .bus_req_addr(bus_req_addr), .bus_req_wmask(bus_req_wmask), .bus_req_wdata(bus_req_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_resp_error(bus_resp_error), .bus_resp_rdata(bus_resp_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Responder / monitor state (written only by the responder process)
  logic        mute = 1'b0;
  logic        resp_err = 1'b0;
  logic [63:0] resp_data = '0;
  logic        hs;
  int          n_req = 0;
  int          rd_pulses = 0;
  int          wr_err_pulses = 0;
  logic [63:0] log_addr [64];
  logic [63:0] log_data [64];
  logic [7:0]  log_mask [64];
  logic        log_wen  [64];

  initial begin
    bus_resp_valid = 1'b0;
    bus_resp_error = 1'b0;
    bus_resp_rdata = '0;
    forever begin
      @(negedge clk);
      hs = bus_req_valid && bus_req_ready && !rst;
      if (hs && n_req < 64) begin
        log_addr[n_req] = bus_req_addr;
        log_data[n_req] = bus_req_wdata;
        log_mask[n_req] = bus_req_wmask;
        log_wen[n_req]  = bus_req_wen;
        n_req++;
      end
      if (data_Rd_valid) rd_pulses++;
      if (data_Wr_error) wr_err_pulses++;
      @(posedge clk);
      #1;
      bus_resp_valid = hs && !mute;
      bus_resp_error = hs && !mute && resp_err;
      bus_resp_rdata = (hs && !mute) ? resp_data : '0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [63:0] a, input logic [7:0] m, input logic [63:0] d);
    MemWr = 1'b1; addr = a; wr_mask = m; data_Wr = d; cpu_block = 1'b0;
    tick(1);
    MemWr = 1'b0;
  endtask

  task automatic do_load(input logic [63:0] a, output int lat, output logic [63:0] d, output logic e);
    int   c0;
    logic found;
    MemRd = 1'b1; addr = a;
    c0 = cyc; found = 1'b0; lat = -1; d = '0; e = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (data_Rd_valid) begin
        found = 1'b1; lat = cyc - c0; d = data_Rd; e = data_Rd_error;
      end
    end
    check("load_done", found, 1);
    @(posedge clk);
    #1;
    MemRd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int          lat, base_req, base_rd, base_we;
  logic [63:0] rd;
  logic        re;

  initial begin
    rst = 1'b1; MemRd = 1'b0; MemWr = 1'b0; cpu_block = 1'b0;
    addr = '0; wr_mask = '0; data_Wr = '0; bus_req_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data_Rd", data_Rd, 0);
    check("rst_flags", {data_Rd_valid, data_Rd_error, data_Wr_error, wr_full}, 0);
    check("rst_req_valid", bus_req_valid, 0);
    check("rst_req_fields", {bus_req_wen, bus_req_wmask} | bus_req_addr | bus_req_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);

    // Single load
    base_req = n_req; base_rd = rd_pulses;
    resp_data = 64'h1122_3344_5566_7788;
    do_load(64'h8000_0014, lat, rd, re);
    check("ld_latency", lat, 3);
    check("ld_data", rd, 64'h1122_3344_5566_7788);
    check("ld_error", re, 0);
    tick(3);
    check("ld_pulses", rd_pulses - base_rd, 1);
    check("ld_nreq", n_req - base_req, 1);
    check("ld_req_addr", log_addr[base_req], 64'h8000_0010);
    check("ld_req_wen", log_wen[base_req], 0);

    // Store then load: write must reach the bus first
    base_req = n_req;
    resp_data = 64'h0;
    store(64'h8000_0000, 8'h0F, 64'hDEAD_BEEF);
    do_load(64'h8000_0000, lat, rd, re);
    check("st_ld_latency_ge5", lat >= 5, 1);
    check("st_ld_wr_wen", log_wen[base_req], 1);
    check("st_ld_wr_addr", log_addr[base_req], 64'h8000_0000);
    check("st_ld_wr_mask", log_mask[base_req], 8'h0F);
    check("st_ld_wr_data", log_data[base_req], 64'hDEAD_BEEF);
    check("st_ld_rd_wen", log_wen[base_req+1], 0);
    check("st_ld_rd_addr", log_addr[base_req+1], 64'h8000_0000);
    tick(2);

    // Buffer full
    bus_req_ready = 1'b0;
    base_req = n_req;
    for (int i = 0; i < 4; i++) store(64'h100 + 64'(8*i), 8'hFF, 64'hA0 + 64'(i));
    @(negedge clk);
    check("full_set", wr_full, 1);
    check("full_req_valid", bus_req_valid, 1);
    check("full_req_addr_head", bus_req_addr, 64'h100);
    tick(1);
    store(64'h200, 8'hFF, 64'hBAD);
    tick(2);
    @(negedge clk);
    check("full_held", wr_full, 1);
    check("full_no_req", n_req - base_req, 0);
    check("full_req_stable", bus_req_addr, 64'h100);
    tick(1);
    bus_req_ready = 1'b1;
    tick(1);
    @(negedge clk);
    check("full_clear", wr_full, 0);
    tick(20);
    check("full_nwrites", n_req - base_req, 4);
    for (int i = 0; i < 4; i++) begin
      check("full_wr_addr", log_addr[base_req+i], 64'h100 + 64'(8*i));
      check("full_wr_data", log_data[base_req+i], 64'hA0 + 64'(i));
      check("full_wr_wen", log_wen[base_req+i], 1);
    end

    // cpu_block gating
    base_req = n_req;
    MemWr = 1'b1; addr = 64'h300; wr_mask = 8'h01; data_Wr = 64'h55; cpu_block = 1'b1;
    tick(1);
    tick(1);
    cpu_block = 1'b0;
    tick(1);
    MemWr = 1'b0;
    tick(10);
    check("blk_nwrites", n_req - base_req, 1);
    check("blk_wr_addr", log_addr[base_req], 64'h300);

    // Load bus error
    resp_err = 1'b1; resp_data = 64'hCAFE;
    do_load(64'h40, lat, rd, re);
    resp_err = 1'b0;
    check("ld_err_flag", re, 1);
    check("ld_err_data", rd, 64'hCAFE);
    tick(2);

    // Store bus error
    base_we = wr_err_pulses;
    resp_err = 1'b1;
    store(64'h48, 8'hFF, 64'h1);
    tick(8);
    resp_err = 1'b0;
    check("st_err_pulses", wr_err_pulses - base_we, 1);

    // Reset in RRESP with two stores buffered
    mute = 1'b1;
    base_req = n_req; base_rd = rd_pulses;
    MemRd = 1'b1; addr = 64'h500;
    tick(2);
    store(64'h500, 8'hFF, 64'h11);
    store(64'h500, 8'hFF, 64'h22);
    rst = 1'b1; MemRd = 1'b0;
    tick(1);
    @(negedge clk);
    check("mid_rst_data_Rd", data_Rd, 0);
    check("mid_rst_flags", {data_Rd_valid, data_Rd_error, data_Wr_error, wr_full}, 0);
    check("mid_rst_req_valid", bus_req_valid, 0);
    check("mid_rst_req_fields", {bus_req_wen, bus_req_wmask} | bus_req_addr | bus_req_wdata, 0);
    tick(1);
    rst = 1'b0; mute = 1'b0;
    tick(15);
    check("mid_rst_nreq", n_req - base_req, 1);
    check("mid_rst_no_rd", rd_pulses - base_rd, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
